// File: rtl/acc_inval_queue_pkg.sv
// Shared types and defaults for the accelerator invalidation queue.
package acc_inval_queue_pkg;

  // D-cache line width in bits; the line offset is log2 of bytes per line.
  localparam int unsigned DCACHE_LINE_WIDTH = 128;
  localparam int unsigned INVAL_LINE_OFFSET = $clog2(DCACHE_LINE_WIDTH / 8);
  localparam int unsigned INVAL_ADDR_WIDTH  = 64;

  // One queued entry: a line-aligned invalidation address.
  typedef logic [INVAL_ADDR_WIDTH-1:0] inval_line_t;

endpackage

// File: rtl/acc_inval_queue.sv
// Accelerator invalidation queue: line-aligns requests, merges back-to-back
// duplicates of the youngest entry, drops requests while coherence is off and
// presents entries one at a time to the core's invalidation port.
module acc_inval_queue
  import acc_inval_queue_pkg::*;
#(
  parameter int unsigned Depth      = 4,
  parameter int unsigned AddrWidth  = INVAL_ADDR_WIDTH,
  parameter int unsigned LineOffset = INVAL_LINE_OFFSET
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       cons_en_i,
  input  logic                       flush_i,
  input  logic [AddrWidth-1:0]       req_addr_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  output logic [AddrWidth-1:0]       inval_addr_o,
  output logic                       inval_valid_o,
  input  logic                       inval_ready_i,
  output logic [$clog2(Depth):0]     usage_o,
  output logic                       merged_o,
  output logic                       dropped_o
);

  localparam int unsigned            PtrW     = $clog2(Depth);
  localparam int unsigned            CntW     = PtrW + 1;
  localparam logic [CntW-1:0]        FullCnt  = CntW'(Depth);
  localparam logic [CntW-1:0]        OneCnt   = CntW'(1);
  localparam logic [AddrWidth-1:0]   LineMask = {AddrWidth{1'b1}} << LineOffset;

  logic [AddrWidth-1:0] r_mem [Depth];
  logic [PtrW-1:0]      r_head, r_tail;
  logic [CntW-1:0]      r_cnt;

  logic [AddrWidth-1:0] w_line;
  logic [PtrW-1:0]      w_tail_m1;
  logic                 w_empty, w_full, w_pop, w_last_pop, w_hit, w_push;

  assign w_line     = req_addr_i & LineMask;
  assign w_tail_m1  = r_tail - PtrW'(1);
  assign w_empty    = (r_cnt == '0);
  assign w_full     = (r_cnt == FullCnt);
  // The youngest entry is leaving only when it is also the sole entry.
  assign w_last_pop = (r_cnt == OneCnt) & inval_ready_i;
  assign w_hit      = ~w_empty & (w_line == r_mem[w_tail_m1]) & ~w_last_pop;
  assign w_pop      = ~w_empty & inval_ready_i & ~flush_i;
  assign w_push     = req_valid_i & cons_en_i & ~flush_i & ~w_hit & ~w_full;

  // Full queue is never made ready by a same-cycle pop.
  assign req_ready_o   = ~cons_en_i | (~flush_i & (w_hit | ~w_full));
  assign merged_o      = req_valid_i & cons_en_i & ~flush_i & w_hit;
  assign dropped_o     = req_valid_i & ~cons_en_i;

  assign inval_valid_o = ~w_empty;
  assign inval_addr_o  = r_mem[r_head];
  assign usage_o       = r_cnt;

  // Pointer and occupancy bookkeeping; flush wins over push and pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else if (flush_i) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_pop)  r_head <= r_head + PtrW'(1);
      if (w_push) r_tail <= r_tail + PtrW'(1);
      r_cnt <= r_cnt + CntW'(w_push) - CntW'(w_pop);
    end
  end

  // Entry storage; cleared on reset so the head address reads zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_tail] <= w_line;
    end
  end

endmodule

// File: tb/tb_acc_inval_queue.sv
// Self-checking bench for acc_inval_queue: queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_acc_inval_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cons_en = 1'b1, flush = 1'b0, req_valid = 1'b0, inval_ready = 1'b0;
  logic [63:0] req_addr = '0;
  logic        req_ready, inval_valid, merged, dropped;
  logic [63:0] inval_addr;
  logic [2:0]  usage;

  int n_cmp = 0, n_err = 0;
  int mcnt = 0, dcnt = 0;
  logic [63:0] q[$];

  acc_inval_queue dut (
    .clk_i(clk), .rst_ni(rst_n), .cons_en_i(cons_en), .flush_i(flush),
    .req_addr_i(req_addr), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .inval_addr_o(inval_addr), .inval_valid_o(inval_valid),
    .inval_ready_i(inval_ready), .usage_o(usage),
    .merged_o(merged), .dropped_o(dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: expected behaviour from the queue contents and current inputs.
  function automatic logic [63:0] m_line();
    return req_addr & ~64'hF;
  endfunction
  function automatic bit m_merge();
    if (!cons_en || flush || q.size() == 0) return 1'b0;
    if (q.size() == 1 && inval_ready) return 1'b0;
    return m_line() == q[q.size()-1];
  endfunction
  function automatic bit m_ready();
    return !cons_en || (!flush && (m_merge() || q.size() < 4));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) q.delete();
    else if (flush) q.delete();
    else begin
      bit do_push, do_pop;
      logic [63:0] ln;
      ln      = m_line();
      do_push = req_valid && cons_en && !m_merge() && q.size() < 4;
      do_pop  = q.size() != 0 && inval_ready;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(ln);
    end
  end

  // Per-cycle compare on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("valid", 64'(inval_valid), 64'(q.size() != 0));
      chk("usage", 64'(usage), 64'(q.size()));
      chk("req_ready", 64'(req_ready), 64'(m_ready()));
      chk("merged", 64'(merged), 64'(req_valid && m_merge()));
      chk("dropped", 64'(dropped), 64'(req_valid && !cons_en));
      if (q.size() != 0) chk("inval_addr", inval_addr, q[0]);
      if (merged) mcnt++;
      if (dropped) dcnt++;
    end
  end

  task automatic set_in(input logic v, input logic [63:0] a, input logic c,
                        input logic r, input logic f);
    req_valid = v; req_addr = a; cons_en = c; inval_ready = r; flush = f;
  endtask
  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic go(input logic v, input logic [63:0] a, input logic c,
                    input logic r, input logic f);
    set_in(v, a, c, r, f); step();
  endtask

  initial begin
    int m0, d0;
    #3;
    chk("rst_valid", 64'(inval_valid), 64'd0);
    chk("rst_addr", inval_addr, 64'd0);
    chk("rst_usage", 64'(usage), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_merged", 64'(merged), 64'd0);
    chk("rst_dropped", 64'(dropped), 64'd0);
    #9 rst_n = 1'b1;
    step();

    // Basic enqueue with alignment
    go(1, 64'h1003, 1, 0, 0);
    chk("t1_addr", inval_addr, 64'h1000);
    chk("t1_valid", 64'(inval_valid), 64'd1);
    chk("t1_usage", 64'(usage), 64'd1);
    go(0, 0, 1, 1, 0);
    chk("t1_drained", 64'(usage), 64'd0);

    // Back-to-back merge
    m0 = mcnt;
    go(1, 64'h2000, 1, 0, 0);
    go(1, 64'h2008, 1, 0, 0);
    go(1, 64'h200F, 1, 0, 0);
    set_in(0, 0, 1, 0, 0); #1;
    chk("t2_merges", 64'(mcnt - m0), 64'd2);
    chk("t2_usage", 64'(usage), 64'd1);
    step();
    go(0, 0, 1, 1, 0);

    // Count=1 with sole entry popping: same line pushes anew
    go(1, 64'h1100, 1, 0, 0);
    set_in(1, 64'h1104, 1, 1, 0); #1;
    chk("t2b_no_merge", 64'(merged), 64'd0);
    step();
    chk("t2b_usage", 64'(usage), 64'd1);
    chk("t2b_addr", inval_addr, 64'h1100);
    go(0, 0, 1, 1, 0);

    // Non-adjacent duplicates stay distinct and drain in order
    go(1, 64'h3000, 1, 0, 0);
    go(1, 64'h4000, 1, 0, 0);
    go(1, 64'h3000, 1, 0, 0);
    chk("t3_usage", 64'(usage), 64'd3);
    chk("t3_head0", inval_addr, 64'h3000);
    go(0, 0, 1, 1, 0);
    chk("t3_head1", inval_addr, 64'h4000);
    go(0, 0, 1, 1, 0);
    chk("t3_head2", inval_addr, 64'h3000);
    go(0, 0, 1, 1, 0);
    chk("t3_empty", 64'(inval_valid), 64'd0);

    // Full queue
    go(1, 64'h5000, 1, 0, 0);
    go(1, 64'h6000, 1, 0, 0);
    go(1, 64'h7000, 1, 0, 0);
    go(1, 64'h8000, 1, 0, 0);
    chk("t4_usage_full", 64'(usage), 64'd4);
    set_in(1, 64'h8004, 1, 0, 0); #1;
    chk("t4_ready_tail", 64'(req_ready), 64'd1);
    set_in(1, 64'h9000, 1, 0, 0); #1;
    chk("t4_ready_new", 64'(req_ready), 64'd0);
    set_in(1, 64'h9000, 1, 1, 0); #1;
    chk("t4_ready_popping", 64'(req_ready), 64'd0);
    step();
    chk("t4_usage_pop", 64'(usage), 64'd3);
    set_in(1, 64'h9000, 1, 0, 0); #1;
    chk("t4_ready_next", 64'(req_ready), 64'd1);
    step();
    chk("t4_usage_refill", 64'(usage), 64'd4);
    chk("t4_head", inval_addr, 64'h6000);
    go(0, 0, 1, 1, 0);
    go(0, 0, 1, 1, 0);
    go(0, 0, 1, 1, 0);
    chk("t4_last", inval_addr, 64'h9000);
    go(0, 0, 1, 1, 0);

    // Coherence off: drops, queued entries still drain
    go(1, 64'hA000, 1, 0, 0);
    go(1, 64'hB000, 1, 0, 0);
    d0 = dcnt;
    go(1, 64'hC000, 0, 0, 0);
    go(1, 64'hD000, 0, 0, 0);
    go(1, 64'hB000, 0, 0, 0);
    set_in(0, 0, 0, 0, 0); #1;
    chk("t5_drops", 64'(dcnt - d0), 64'd3);
    chk("t5_usage", 64'(usage), 64'd2);
    step();
    go(0, 0, 0, 1, 0);
    chk("t5_head", inval_addr, 64'hB000);
    go(0, 0, 0, 1, 0);
    chk("t5_empty", 64'(inval_valid), 64'd0);

    // Flush
    go(1, 64'hE000, 1, 0, 0);
    go(1, 64'hE100, 1, 0, 0);
    go(1, 64'hE200, 1, 0, 0);
    set_in(1, 64'hF000, 0, 0, 1); #1;
    chk("t6_flush_drop_ready", 64'(req_ready), 64'd1);
    set_in(1, 64'hF000, 1, 1, 1); #1;
    chk("t6_flush_ready", 64'(req_ready), 64'd0);
    step();
    chk("t6_usage", 64'(usage), 64'd0);
    chk("t6_valid", 64'(inval_valid), 64'd0);

    // Async reset mid-pop
    go(1, 64'h1230, 1, 0, 0);
    go(1, 64'h4560, 1, 0, 0);
    set_in(0, 0, 1, 1, 0);
    rst_n = 1'b0; #1;
    chk("t7_valid", 64'(inval_valid), 64'd0);
    chk("t7_usage", 64'(usage), 64'd0);
    chk("t7_addr", inval_addr, 64'd0);
    #2 rst_n = 1'b1;
    set_in(0, 0, 1, 0, 0);
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
